// File: rtl/search_pkg.sv
// rtl/search_pkg.sv - shared types and constants for the search datapath
package search_pkg;

  localparam int ID_W        = 8;
  localparam int MAX_ENGINES = 8;

  typedef logic [ID_W-1:0] result_id_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting at a pointer
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [PTR_W-1:0]   ptr,
  output logic               grant_valid,
  output logic [PTR_W-1:0]   grant_idx
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  // Walk from the farthest offset down to the pointer so the nearest pending index wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    idx         = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) begin
        sum = sum - (PTR_W+1)'(NUM_REQ);
      end
      idx = sum[PTR_W-1:0];
      if (pending[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/result_arbiter.sv
// rtl/result_arbiter.sv - buffers one hit per match engine and serialises them round-robin
module result_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 8
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [7:0]              enable_mask,
  input  logic                    clear,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*ID_W-1:0] req_id,
  output logic                    m_axis_tvalid,
  output logic [ID_W-1:0]         m_axis_tdata,
  output logic [NUM_REQ-1:0]      overflow,
  output logic [7:0]              drop_count,
  output logic                    busy
);

  import search_pkg::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] grant_oh;
  logic [NUM_REQ-1:0] cap;
  logic [NUM_REQ-1:0] drop;
  logic [NUM_REQ-1:0] mask_used;
  result_id_t         ids [NUM_REQ];
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   ptr_nxt;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_valid;
  logic [3:0]         n_drop;
  logic [8:0]         drop_sum;
  logic               unused_mask;

  assign mask_used   = enable_mask[NUM_REQ-1:0];
  assign unused_mask = ^enable_mask;
  assign busy        = (|pending) | m_axis_tvalid;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .pending     (pending),
    .ptr         (ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Decide per engine whether a hit is captured or dropped, and tally the drops.
  always_comb begin
    grant_oh = '0;
    if (grant_valid) begin
      grant_oh[grant_idx] = 1'b1;
    end
    // A granted slot frees up this edge, so a hit arriving with its grant reloads it.
    cap    = req_valid & mask_used & (~pending | grant_oh);
    drop   = req_valid & mask_used & pending & ~grant_oh;
    n_drop = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      n_drop = n_drop + {3'b000, drop[i]};
    end
    drop_sum = {1'b0, drop_count} + {5'b00000, n_drop};
    if (NUM_REQ == 1) begin
      ptr_nxt = '0;
    end else if (grant_idx == PTR_W'(NUM_REQ - 1)) begin
      ptr_nxt = '0;
    end else begin
      ptr_nxt = grant_idx + 1'b1;
    end
  end

  // Buffer state, round-robin pointer, registered output and loss bookkeeping.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pending       <= '0;
      ptr           <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      overflow      <= '0;
      drop_count    <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        ids[i] <= '0;
      end
    end else if (clear) begin
      pending       <= '0;
      ptr           <= '0;
      m_axis_tvalid <= 1'b0;
      overflow      <= '0;
      drop_count    <= '0;
    end else begin
      m_axis_tvalid <= grant_valid;
      if (grant_valid) begin
        m_axis_tdata <= ids[grant_idx];
        ptr          <= ptr_nxt;
      end
      pending    <= (pending & ~grant_oh) | cap;
      overflow   <= overflow | drop;
      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cap[i]) begin
          ids[i] <= req_id[i*ID_W +: ID_W];
        end
      end
    end
  end

endmodule
